// File: rtl/sdram_arbit.sv
// sdram_arbit: single-owner SDRAM bus arbiter (refresh > write > read) with pin mux.
// Define SDRAM_ARBIT_RR_EN to alternate write/read grants when both request together.
module sdram_arbit #(
   parameter int CMD_W = 4,
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2,
   parameter logic [CMD_W-1:0] NOP_CMD = 4'b0111,
   parameter logic [ADDR_W-1:0] IDLE_ADDR = 13'h0400
) (
   input  logic              sysclk_100M,
   input  logic              rst,
   input  logic              init_done,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              refresh_req,
   output logic              ref_ack,
   input  logic              ref_end,
   input  logic [CMD_W-1:0]  ref_cmd,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic              arbit_write_req,
   output logic              arbit_write_ack,
   input  logic              write_prech_end,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic              arbit_read_req,
   output logic              arbit_read_ack,
   input  logic              arbit_prech_end,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BANK_W-1:0] rd_bank,
   output logic [CMD_W-1:0]  sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BANK_W-1:0] sdram_bank_addr,
   output logic [2:0]        owner
);
   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_IDLE  = 5'b00010,
      S_REF   = 5'b00100,
      S_WRITE = 5'b01000,
      S_READ  = 5'b10000
   } state_t;
   state_t state;
   logic last_rd;
   logic pick_wr;
`ifdef SDRAM_ARBIT_RR_EN
   // on a write/read tie, grant whichever engine did not win last time
   assign pick_wr = arbit_write_req && !(arbit_read_req && !last_rd);
`else
   logic unused_last_rd;
   assign pick_wr = arbit_write_req;
   assign unused_last_rd = last_rd;
`endif
   always_ff @(posedge sysclk_100M) begin
      if (rst) begin
         state <= S_INIT;
         ref_ack <= 1'b0;
         arbit_write_ack <= 1'b0;
         arbit_read_ack <= 1'b0;
         owner <= 3'b000;
         last_rd <= 1'b1;
      end else begin
         ref_ack <= 1'b0;
         arbit_write_ack <= 1'b0;
         arbit_read_ack <= 1'b0;
         case (state)
            S_INIT: if (init_done) state <= S_IDLE;
            S_IDLE: begin
               if (refresh_req) begin
                  state <= S_REF;
                  ref_ack <= 1'b1;
                  owner <= 3'b001;
               end else if (pick_wr) begin
                  state <= S_WRITE;
                  arbit_write_ack <= 1'b1;
                  owner <= 3'b010;
                  last_rd <= 1'b0;
               end else if (arbit_read_req) begin
                  state <= S_READ;
                  arbit_read_ack <= 1'b1;
                  owner <= 3'b100;
                  last_rd <= 1'b1;
               end
            end
            S_REF: if (ref_end) begin
               state <= S_IDLE;
               owner <= 3'b000;
            end
            S_WRITE: if (write_prech_end) begin
               state <= S_IDLE;
               owner <= 3'b000;
            end
            S_READ: if (arbit_prech_end) begin
               state <= S_IDLE;
               owner <= 3'b000;
            end
            default: begin
               state <= S_INIT;
               owner <= 3'b000;
            end
         endcase
      end
   end
   always_comb begin
      sdram_cmd = state == S_INIT ? init_cmd : state == S_REF ? ref_cmd :
                  state == S_WRITE ? wr_cmd : state == S_READ ? rd_cmd : NOP_CMD;
      sdram_addr = state == S_INIT ? init_addr : state == S_REF ? ref_addr :
                   state == S_WRITE ? wr_addr : state == S_READ ? rd_addr : IDLE_ADDR;
      sdram_bank_addr = state == S_WRITE ? wr_bank : state == S_READ ? rd_bank : '0;
   end
endmodule
